// File: rtl/fp_pack_round.sv
// Sequential IEEE-754 single-precision packer: iterative normalization (one shift
// per cycle), round-to-nearest-even, exception flags, valid/ready on both sides.
module fp_pack_round #(
  parameter int unsigned EXP_W  = 10,
  parameter int unsigned MANT_W = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  input  logic              in_nan,
  input  logic              in_inf,
  input  logic              in_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_fp,
  output logic              out_overflow,
  output logic              out_underflow,
  output logic              out_inexact
);

  localparam int unsigned CARRY = MANT_W - 1;
  localparam int unsigned HID   = MANT_W - 2;
  localparam int unsigned HI_W  = MANT_W - 3;

  localparam logic signed [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
  localparam logic signed [EXP_W-1:0] EXP_DEEP = EXP_W'(-26);
  localparam logic signed [EXP_W-1:0] EXP_MAX  = EXP_W'(255);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_NORM  = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]              state_q,     state_d;
  logic                    in_ready_q,  in_ready_d;
  logic                    sign_q,      sign_d;
  logic signed [EXP_W-1:0] exp_q,       exp_d;
  logic [MANT_W-1:0]       mant_q,      mant_d;
  logic                    out_valid_q, out_valid_d;
  logic [31:0]             out_fp_q,    out_fp_d;
  logic                    ovf_q,       ovf_d;
  logic                    udf_q,       udf_d;
  logic                    inx_q,       inx_d;

  // Rounding datapath, only consumed in ROUND
  logic                    rnd_g, rnd_rs, rnd_lsb, rnd_up, rnd_carry, rnd_hid, rnd_inx;
  logic [HI_W-1:0]         rnd_sum;
  logic [22:0]             rnd_frac;
  logic signed [EXP_W-1:0] rnd_exp;
  logic [7:0]              rnd_ef;

  always_comb begin
    rnd_lsb   = mant_q[3];
    rnd_g     = mant_q[2];
    rnd_rs    = mant_q[1] | mant_q[0];
    rnd_up    = rnd_g & (rnd_rs | rnd_lsb);
    rnd_inx   = rnd_g | rnd_rs;
    rnd_sum   = mant_q[CARRY:3] + HI_W'(rnd_up);
    rnd_carry = rnd_sum[HI_W-1];
    rnd_hid   = rnd_sum[HI_W-1] | rnd_sum[HI_W-2];
    rnd_frac  = rnd_carry ? rnd_sum[HI_W-2:1] : rnd_sum[HI_W-3:0];
    rnd_exp   = rnd_carry ? exp_q + EXP_ONE : exp_q;
    rnd_ef    = rnd_hid ? rnd_exp[7:0] : 8'h00;
  end

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    mant_d      = mant_q;
    out_valid_d = out_valid_q;
    out_fp_d    = out_fp_q;
    ovf_d       = ovf_q;
    udf_d       = udf_q;
    inx_d       = inx_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          in_ready_d = 1'b0;
          sign_d     = in_sign;
          exp_d      = $signed(in_exp);
          mant_d     = in_mant;
          ovf_d      = 1'b0;
          udf_d      = 1'b0;
          inx_d      = 1'b0;
          if (in_nan || in_inf || in_zero || (in_mant == '0)) begin
            if (in_nan) begin
              out_fp_d = 32'h7FC0_0000;
            end else if (in_inf) begin
              out_fp_d = {in_sign, 8'hFF, 23'h0};
            end else begin
              out_fp_d = {in_sign, 31'h0};
            end
            out_valid_d = 1'b1;
            state_d     = S_OUT;
          end else if ($signed(in_exp) <= EXP_DEEP) begin
            // Too small to reach even the smallest subnormal: keep only sticky
            mant_d  = MANT_W'(1);
            exp_d   = EXP_ONE;
            state_d = S_ROUND;
          end else begin
            state_d = S_NORM;
          end
        end
      end

      S_NORM: begin
        if (mant_q[CARRY] || (exp_q < EXP_ONE)) begin
          mant_d = {1'b0, mant_q[CARRY:2], mant_q[1] | mant_q[0]};
          exp_d  = exp_q + EXP_ONE;
        end else if (!mant_q[HID] && (exp_q > EXP_ONE)) begin
          mant_d = {mant_q[CARRY-1:0], 1'b0};
          exp_d  = exp_q - EXP_ONE;
        end else begin
          state_d = S_ROUND;
        end
      end

      S_ROUND: begin
        if (rnd_exp >= EXP_MAX) begin
          out_fp_d = {sign_q, 8'hFF, 23'h0};
          ovf_d    = 1'b1;
          udf_d    = 1'b0;
          inx_d    = 1'b1;
        end else begin
          out_fp_d = {sign_q, rnd_ef, rnd_frac};
          ovf_d    = 1'b0;
          udf_d    = (rnd_ef == 8'h00) && rnd_inx;
          inx_d    = rnd_inx;
        end
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end

      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      out_valid_q <= 1'b0;
      out_fp_q    <= '0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      inx_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mant_q      <= mant_d;
      out_valid_q <= out_valid_d;
      out_fp_q    <= out_fp_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
      inx_q       <= inx_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_fp        = out_fp_q;
  assign out_overflow  = ovf_q;
  assign out_underflow = udf_q;
  assign out_inexact   = inx_q;

endmodule

// File: tb/tb_fp_pack_round.sv
// Directed bench for fp_pack_round: hand-computed results, flags and latencies.
module tb_fp_pack_round;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [27:0] in_mant;
  logic        in_nan;
  logic        in_inf;
  logic        in_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_fp;
  logic        out_overflow;
  logic        out_underflow;
  logic        out_inexact;

  int vectors;
  int miscompares;

  fp_pack_round #(.EXP_W(10), .MANT_W(28)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_exp       (in_exp),
    .in_mant      (in_mant),
    .in_nan       (in_nan),
    .in_inf       (in_inf),
    .in_zero      (in_zero),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_fp       (out_fp),
    .out_overflow (out_overflow),
    .out_underflow(out_underflow),
    .out_inexact  (out_inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {29'h0, out_overflow, out_underflow, out_inexact};
  endfunction

  task automatic handshake(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ".vld_drop"}, 32'(out_valid), 32'd0);
    chk({tag, ".rdy_back"}, 32'(in_ready), 32'd1);
  endtask

  // efl = {overflow, underflow, inexact}
  task automatic do_op(input string tag, input logic s, input logic [9:0] e,
                       input logic [27:0] m, input logic nan, input logic inf,
                       input logic zero, input logic [31:0] efp, input logic [2:0] efl,
                       input int elat, input bit take);
    int lat;
    @(negedge clk);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    in_nan   = nan;
    in_inf   = inf;
    in_zero  = zero;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_nan   = 1'b0;
    in_inf   = 1'b0;
    in_zero  = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(elat));
    chk({tag, ".fp"}, out_fp, efp);
    chk({tag, ".flags"}, flags(), {29'h0, efl});
    if (take) handshake(tag);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    in_nan    = 1'b0;
    in_inf    = 1'b0;
    in_zero   = 1'b0;
    out_ready = 1'b0;

    #12;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_fp", out_fp, 32'h0);
    chk("rst.flags", flags(), 32'h0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("one",      1'b0, 10'd127, 28'h4000000, 0, 0, 0, 32'h3F80_0000, 3'b000, 3, 1);
    do_op("two",      1'b0, 10'd127, 28'h8000000, 0, 0, 0, 32'h4000_0000, 3'b000, 4, 1);
    do_op("tie_even", 1'b0, 10'd127, 28'h4000004, 0, 0, 0, 32'h3F80_0000, 3'b001, 3, 1);
    do_op("tie_odd",  1'b0, 10'd127, 28'h400000C, 0, 0, 0, 32'h3F80_0002, 3'b001, 3, 1);
    do_op("ovf",      1'b0, 10'd254, 28'h7FFFFFF, 0, 0, 0, 32'h7F80_0000, 3'b101, 3, 1);
    do_op("subn",     1'b0, 10'd0,   28'h4000000, 0, 0, 0, 32'h0040_0000, 3'b000, 4, 1);
    do_op("lshift2",  1'b1, 10'd127, 28'h1000000, 0, 0, 0, 32'hBE80_0000, 3'b000, 5, 1);
    do_op("sub2norm", 1'b0, 10'd1,   28'h3FFFFFC, 0, 0, 0, 32'h0080_0000, 3'b001, 3, 1);
    do_op("nan",      1'b1, 10'd127, 28'h4000000, 1, 1, 1, 32'h7FC0_0000, 3'b000, 1, 1);
    do_op("inf",      1'b1, 10'd5,   28'h4000000, 0, 1, 1, 32'hFF80_0000, 3'b000, 1, 1);
    do_op("zero",     1'b1, 10'd127, 28'h4000000, 0, 0, 1, 32'h8000_0000, 3'b000, 1, 1);
    do_op("mant0",    1'b0, 10'd127, 28'h0000000, 0, 0, 0, 32'h0000_0000, 3'b000, 1, 1);
    do_op("deep",     1'b0, 10'h3D8, 28'h4000000, 0, 0, 0, 32'h0000_0000, 3'b011, 2, 1);

    // Output held while consumer stalls; new requests are ignored
    do_op("hold", 1'b0, 10'd127, 28'h4000000, 0, 0, 0, 32'h3F80_0000, 3'b000, 3, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_nan   = 1'b1;
      @(posedge clk);
      #1;
      chk("hold.fp", out_fp, 32'h3F80_0000);
      chk("hold.flags", flags(), 32'h0);
      chk("hold.vld", 32'(out_valid), 32'd1);
      chk("hold.in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_nan    = 1'b0;
    chk("hold.vld_drop", 32'(out_valid), 32'd0);
    chk("hold.rdy_back", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("hold.no_accept", 32'(out_valid), 32'd0);
    do_op("after_hold", 1'b0, 10'd128, 28'h6000000, 0, 0, 0, 32'h4040_0000, 3'b000, 3, 1);

    // Reset in the middle of a long left-normalization
    @(negedge clk);
    in_exp   = 10'd127;
    in_mant  = 28'h0000008;
    in_sign  = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst.busy", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.vld", 32'(out_valid), 32'd0);
    chk("midrst.fp", out_fp, 32'h0);
    chk("midrst.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("post_rst", 1'b0, 10'd127, 28'h4000000, 0, 0, 0, 32'h3F80_0000, 3'b000, 3, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fp_pack_round.md
Name: fp_pack_round

Overview:
- Sequential IEEE-754 single-precision packer. Counterpart of the unpack stage used by the comparators.
- Accepts an unnormalized sign/exponent/extended-mantissa result from the arithmetic datapaths (add/mul/div) and normalizes it iteratively, one shift per cycle.
- Rounds round-to-nearest-even and packs it into a 32-bit word with IEEE exception flags.
- Valid/ready on both sides; one operation in flight.

Parameters:
- EXP_W, 10, width of signed two's-complement biased exponent input
- MANT_W, 28, extended mantissa width: [27] carry, [26] hidden, [25:3] fraction, [2] guard, [1] round, [0] sticky

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input operand valid
- in_ready  out  1  block can accept (high only in IDLE)
- in_sign  in  1  result sign
- in_exp  in  EXP_W  signed biased exponent; value = (in_mant/2^26)*2^(in_exp-127)
- in_mant  in  MANT_W  extended mantissa
- in_nan  in  1  force quiet NaN
- in_inf  in  1  force infinity with in_sign
- in_zero  in  1  force zero with in_sign
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_fp  out  32  packed IEEE-754 result
- out_overflow  out  1  result overflowed to infinity
- out_underflow  out  1  result tiny (exp field 0) and inexact
- out_inexact  out  1  rounding discarded nonzero bits

Behaviour:
- Reset: async on rst_n low. State IDLE, out_valid=0, out_fp=0, all flags 0, internal regs 0. in_ready=1 in IDLE. Reset mid-operation aborts the job with no output.
- Accept: on an edge with in_valid&&in_ready. Capture all inputs; in_ready drops next cycle.
- States: IDLE, NORM, ROUND, OUT.
- Special-input priority on accept: nan > inf > zero.
  - nan: goes to OUT directly with out_fp=32'h7FC00000.
  - inf: out_fp={sign,8'hFF,23'b0}.
  - zero, or in_mant==0: out_fp={sign,31'b0}.
  - All flags 0.
- Deep-underflow input (in_exp <= -26, nonzero mant): skip NORM. Mant := 0 with sticky=1, exp := 1, go to ROUND. Result is ±0 with inexact=1, underflow=1.
- Otherwise accept goes to NORM. Each NORM cycle applies exactly one rule, in this priority order:
  - mant[27]=1: shift right 1 (bit0 = old bit1|old bit0), exp+1.
  - exp<1: shift right 1 with sticky, exp+1.
  - mant[26]=0 and exp>1: shift left 1, exp-1.
  - Else go to ROUND (mant[26]=0 at exp=1 means subnormal).
- ROUND, one cycle, RNE:
  - lsb=mant[3], g=mant[2], rs=mant[1]|mant[0].
  - Round up iff g&&(rs||lsb); round-up adds 8 to mant.
  - Carry into bit27: shift right 1, exp+1. A subnormal rounding into bit26 becomes normal, exponent field 1.
  - inexact = g|rs before rounding.
  - exp>=255 after rounding: out_fp={sign,8'hFF,0}, overflow=1, inexact=1.
  - Else exp field = mant[26] ? exp[7:0] : 0; fraction = mant[25:3].
  - underflow = (exp field==0) && inexact.
  - Go to OUT.
- OUT: out_valid=1 with out_fp and flags held stable until out_valid&&out_ready. On that edge: out_valid=0, go to IDLE, in_ready=1 next cycle. No input is accepted in the same cycle the output is taken.
- Latency, acceptance edge to first cycle out_valid=1:
  - 3+n cycles for the NORM path (n = number of shifts).
  - 1 cycle for special inputs.
  - 2 cycles for deep-underflow inputs.
- Inputs are ignored outside IDLE. out_ready is ignored outside OUT.
- Exponent arithmetic is EXP_W signed and cannot wrap: left shifts stop at exp=1, right shifts are bounded by carry and deep-underflow limits.

Test Plan:
- sign=0, exp=127, mant=28'h4000000 -> out_fp=32'h3F800000, flags 0, out_valid 3 cycles after accept; same with mant=28'h8000000 -> 32'h40000000 at 4 cycles.
- exp=127, mant=28'h4000004 (tie, lsb 0) -> 32'h3F800000, inexact=1; mant=28'h400000C (tie, lsb 1) -> 32'h3F800002, inexact=1.
- exp=254, mant=28'h7FFFFFF -> 32'h7F800000, overflow=1, inexact=1; exp=0, mant=28'h4000000 -> 32'h00400000 after 1 shift, underflow=0.
- in_nan=1 -> 32'h7FC00000 after 1 cycle; in_inf=1, sign=1 -> 32'hFF800000; exp=-40, mant=28'h4000000 -> 32'h00000000, inexact=1, underflow=1.
- Hold out_ready=0 for 5 cycles in OUT: out_fp/flags stable, in_ready=0, new in_valid ignored; raise out_ready -> handshake, in_ready=1 next cycle.
- Assert rst_n=0 mid-NORM (exp=127, mant=28'h0000008): outputs clear immediately; after release in_ready=1, next operation correct.
